prefetch_module: RTL and testbench

//  Parametrised successor to the pipeline fetch stage. Generates the PC stream to instruction

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/prefetch_module.sv | 94 +++++++++
 tb/tb_prefetch_module.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, reset PC and the branch-bus layout used by
// both the fetch stage and decode.
package cpu_pkg;

    localparam int          ADDR_W   = 16;
    localparam int          DATA_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    // brbus = {valid, taken, target[ADDR_W-1:0]}
    localparam int BR_VALID  = ADDR_W + 1;
    localparam int BR_TAKEN  = ADDR_W;
    localparam int BR_TGT_HI = ADDR_W - 1;
    localparam int BR_TGT_LO = 0;

    function automatic int brbus_w(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO with synchronous clear, simultaneous push/pop at any
// occupancy (including full) and an occupancy count.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + PTR_ONE;
            end
            if (pop_i) rd_q <= rd_q + PTR_ONE;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/prefetch_module.sv
// Fetch stage: drives the PC stream to instruction memory, queues returned instructions
// with their PC and hands them to decode; taken branches redirect and flush wrong-path work.
module prefetch_module #(
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
    input  logic                                clock,
    input  logic                                reset,
    output logic                                imem_req,
    output logic [ADDR_W-1:0]                   imem_addr,
    input  logic [DATA_W-1:0]                   imem_rdata,
    input  logic [cpu_pkg::brbus_w(ADDR_W)-1:0] brbus,
    output logic [DATA_W-1:0]                   inst,
    output logic [ADDR_W-1:0]                   inst_pc,
    output logic                                inst_valid,
    input  logic                                inst_ready,
    output logic [$clog2(DEPTH):0]              queue_count
);

    import cpu_pkg::*;

    localparam int BRV = brbus_w(ADDR_W) - 1;
    localparam int BRT = BRV - 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic              inflight_q, inflight_d;
    logic              req_int;
    logic              redirect;
    logic              credit;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target;

    assign redirect = brbus[BRV] & brbus[BRT];
    assign target   = brbus[ADDR_W-1:0];
    // Pops in this cycle deliberately give no credit, keeping the check off the ready path.
    assign credit   = (32'(queue_count) + 32'(inflight_q)) < DEPTH;

    always_comb begin
        req_int    = 1'b0;
        imem_addr  = pc_q;
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = 1'b0;
        if (redirect) begin
            req_int    = 1'b1;
            imem_addr  = target;
            pc_d       = target + PC_STEP;
            rsp_pc_d   = target;
            inflight_d = 1'b1;
        end else if (credit) begin
            req_int    = 1'b1;
            pc_d       = pc_q + PC_STEP;
            rsp_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    assign imem_req   = reset & req_int;
    assign push       = inflight_q & ~redirect;
    assign inst_valid = (queue_count != '0) & ~redirect;
    assign pop        = inst_valid & inst_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .W     (DATA_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (redirect),
        .push_i  (push),
        .wdata_i ({imem_rdata, rsp_pc_q}),
        .pop_i   (pop),
        .rdata_o ({inst, inst_pc}),
        .count_o (queue_count)
    );

endmodule

// File: tb/tb_prefetch_module.sv
// Bench for prefetch_module: memory returns addr^A5A5; a PC-stream model checks every
// accepted instruction, and scenario tasks check latency, credit, redirect and reset.
module tb_prefetch_module;

    localparam int          DEPTH = 4;
    localparam logic [15:0] KEY   = 16'hA5A5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inst_ready = 1'b0;
    logic [17:0] brbus = '0;

    logic        imem_req, imem_req2;
    logic [15:0] imem_addr, imem_addr2;
    logic [15:0] imem_rdata = '0;
    logic [15:0] imem_rdata2 = '0;
    logic [15:0] inst, inst_pc, inst2, inst_pc2;
    logic        inst_valid, inst_valid2;
    logic [2:0]  queue_count, queue_count2;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_next = 16'h0000;

    always #5 clock = ~clock;

    prefetch_module #(.DEPTH(DEPTH)) u_dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .brbus(brbus), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .queue_count(queue_count)
    );

    prefetch_module #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_dut2 (
        .clock(clock), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .brbus(brbus), .inst(inst2), .inst_pc(inst_pc2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready), .queue_count(queue_count2)
    );

    // Instruction memory: one-cycle read latency, never stalls.
    always @(posedge clock) begin
        if (imem_req)  imem_rdata  <= imem_addr ^ KEY;
        if (imem_req2) imem_rdata2 <= imem_addr2 ^ KEY;
    end

    // Reference model: decode must see RESET_PC, +1, +2 ... restarting at each taken target.
    always begin
        @(negedge clock);
        #2;
        if (!reset) begin
            exp_next = 16'h0000;
        end else begin
            checks++;
            if (queue_count > 3'(DEPTH)) begin
                errors++;
                $display("FAIL sb_occupancy queue_count=%0d limit=%0d", queue_count, DEPTH);
            end
            if (brbus[17] && brbus[16]) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL sb_redirect_valid inst_valid=%b required 0", inst_valid);
                end
                exp_next = brbus[15:0];
            end else if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc !== exp_next || inst !== (exp_next ^ KEY)) begin
                    errors++;
                    $display("FAIL sb_order inst_pc=%h inst=%h required pc=%h inst=%h",
                             inst_pc, inst, exp_next, exp_next ^ KEY);
                end
                exp_next = exp_next + 16'd1;
            end
        end
    end

    task automatic drive(input logic rst, input logic rdy, input logic [17:0] br);
        @(negedge clock);
        reset      = rst;
        inst_ready = rdy;
        brbus      = br;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 18'h3_0040);
        drive(1'b0, 1'b1, 18'h0);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 16'h0 ||
            inst_pc !== 16'h0 || queue_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_state req=%b valid=%b inst=%h pc=%h count=%0d required 0,0,0,0,0",
                     imem_req, inst_valid, inst, inst_pc, queue_count);
        end
    endtask

    task automatic test_stream();
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b1, 18'h0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(c)) begin
                errors++;
                $display("FAIL stream_addr cycle=%0d req=%b addr=%h required 1,%h", c, imem_req, imem_addr, 16'(c));
            end
            checks++;
            if (inst_valid !== (c >= 2)) begin
                errors++;
                $display("FAIL stream_valid cycle=%0d inst_valid=%b required %b", c, inst_valid, c >= 2);
            end
            if (c == 2) begin
                checks++;
                if (inst_pc !== 16'h0000 || inst !== 16'hA5A5) begin
                    errors++;
                    $display("FAIL stream_first pc=%h inst=%h required 0000,A5A5", inst_pc, inst);
                end
            end
        end
    endtask

    task automatic test_stall();
        int nreq = 0;
        drive(1'b0, 1'b0, 18'h0);
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 18'h0);
            if (imem_req) begin
                checks++;
                if (imem_addr !== 16'(nreq)) begin
                    errors++;
                    $display("FAIL stall_addr addr=%h required %h", imem_addr, 16'(nreq));
                end
                nreq++;
            end
        end
        checks++;
        if (nreq != DEPTH || imem_req !== 1'b0 || queue_count !== 3'(DEPTH)) begin
            errors++;
            $display("FAIL stall_credit requests=%0d req=%b count=%0d required %0d,0,%0d",
                     nreq, imem_req, queue_count, DEPTH, DEPTH);
        end
        drive(1'b1, 1'b1, 18'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin
            errors++;
            $display("FAIL stall_release valid=%b pc=%h required 1,0000", inst_valid, inst_pc);
        end
        for (int c = 0; c < 12; c++) drive(1'b1, 1'b1, 18'h0);
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b0, 18'h0);
        for (int c = 0; c < 4; c++) drive(1'b1, 1'b0, 18'h0);
        drive(1'b1, 1'b1, {2'b11, 16'h0040});
        checks++;
        if (queue_count !== 3'd3 || imem_req !== 1'b1 || imem_addr !== 16'h0040 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cycle count=%0d req=%b addr=%h valid=%b required 3,1,0040,0",
                     queue_count, imem_req, imem_addr, inst_valid);
        end
        drive(1'b1, 1'b1, 18'h0);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_gap inst_valid=%b required 0", inst_valid);
        end
        drive(1'b1, 1'b1, 18'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0040 || inst !== (16'h0040 ^ KEY)) begin
            errors++;
            $display("FAIL redirect_target valid=%b pc=%h inst=%h required 1,0040,%h",
                     inst_valid, inst_pc, inst, 16'h0040 ^ KEY);
        end
        for (int c = 0; c < 8; c++) drive(1'b1, 1'b1, 18'h0);
    endtask

    task automatic test_not_taken();
        drive(1'b0, 1'b1, 18'h0);
        for (int c = 0; c < 14; c++) begin
            drive(1'b1, 1'b1, (c == 6) ? {2'b10, 16'h0040} : 18'h0);
            checks++;
            if (imem_addr !== 16'(c) || (c >= 2 && inst_valid !== 1'b1)) begin
                errors++;
                $display("FAIL not_taken cycle=%0d addr=%h valid=%b required %h,1", c, imem_addr, inst_valid, 16'(c));
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] br;
        drive(1'b0, 1'b1, 18'h0);
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 9))
                0:       br = {2'b11, 16'($urandom)};
                1:       br = {2'b10, 16'($urandom)};
                default: br = {1'b0, 17'($urandom)};
            endcase
            drive(1'b1, $urandom_range(0, 3) != 0, br);
        end
    endtask

    task automatic test_wrap();
        exp_q = {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        drive(1'b0, 1'b1, 18'h0);
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b1, 18'h0);
            if (inst_valid2 && exp_q.size() > 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                checks++;
                if (inst_pc2 !== e || inst2 !== (e ^ KEY)) begin
                    errors++;
                    $display("FAIL wrap_pc pc=%h inst=%h required %h,%h", inst_pc2, inst2, e, e ^ KEY);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_timeout remaining=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 18'h0);
        for (int c = 0; c < 4; c++) drive(1'b1, 1'b0, 18'h0);
        drive(1'b1, 1'b0, 18'h0);
        checks++;
        if (queue_count !== 3'd3) begin
            errors++;
            $display("FAIL mid_setup count=%0d required 3", queue_count);
        end
        drive(1'b0, 1'b1, 18'h0);
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0 || queue_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset valid=%b req=%b count=%0d required 0,0,0", inst_valid, imem_req, queue_count);
        end
        drive(1'b1, 1'b1, 18'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL mid_restart req=%b addr=%h required 1,0000", imem_req, imem_addr);
        end
        drive(1'b1, 1'b1, 18'h0);
        checks++;
        if (inst_valid !== 1'b0 || queue_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_stale valid=%b count=%0d required 0,0", inst_valid, queue_count);
        end
        drive(1'b1, 1'b1, 18'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0000 || inst !== 16'hA5A5) begin
            errors++;
            $display("FAIL mid_first valid=%b pc=%h inst=%h required 1,0000,A5A5", inst_valid, inst_pc, inst);
        end
        for (int c = 0; c < 6; c++) drive(1'b1, 1'b1, 18'h0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_not_taken();
        test_random();
        test_wrap();
        test_reset_mid();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
